// File: rtl/riscv_imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: opcodes, NOP word,
// FSM state encodings and an immediate range helper.
package riscv_imem_loader_pkg;

  localparam int unsigned DW = 32;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [DW-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // True when v fits in a 'bits'-wide two's-complement field
  // (all bits above the field's sign bit equal that sign bit).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = bits; i < 32; i++) begin
      if (v[i] != v[bits-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/riscv_encoder.sv
// Combinational RV32I encoder: packs instruction fields and a byte-offset
// immediate into a 32-bit word; flags unsupported opcodes and immediates
// that do not fit, substituting a NOP in that case.
module riscv_encoder
  import riscv_imem_loader_pkg::*;
(
  input  logic [6:0]    opcode_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [2:0]    func3_i,
  input  logic [6:0]    func7_i,
  input  logic [31:0]   imm_i,
  output logic [DW-1:0] inst_o,
  output logic          enc_err_o
);

  // Select the format by opcode; any error replaces the word with NOP.
  always_comb begin
    inst_o    = NOP_INST;
    enc_err_o = 1'b0;
    case (opcode_i)
      OP_IMM, OP_LOAD: begin
        inst_o    = {imm_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
        enc_err_o = !fits_signed(imm_i, 12);
      end
      OP_STORE: begin
        inst_o    = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], opcode_i};
        enc_err_o = !fits_signed(imm_i, 12);
      end
      OP_BRANCH: begin
        inst_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        enc_err_o = !fits_signed(imm_i, 13) || imm_i[0];
      end
      OP_JAL: begin
        inst_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        enc_err_o = !fits_signed(imm_i, 21) || imm_i[0];
      end
      OP_REG: begin
        inst_o    = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
      end
      default: enc_err_o = 1'b1;
    endcase
    if (enc_err_o) inst_o = NOP_INST;
  end

endmodule

// File: rtl/riscv_imem_loader.sv
// Instruction-memory loader: accepts field bundles over valid/ready, encodes
// them and writes the words sequentially from a programmable base address.
module riscv_imem_loader
  import riscv_imem_loader_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_last_i,
  input  logic [6:0]    opcode_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [2:0]    func3_i,
  input  logic [6:0]    func7_i,
  input  logic [31:0]   imm_i,
  output logic          memWr_en_o,
  output logic [AW-1:0] memAddr_o,
  output logic [31:0]   memData_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   count_o,
  output logic          err_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(1) << AW;
  localparam logic [AW:0] LAST_CNT = FULL_CNT - (AW+1)'(1);

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [31:0]   enc_word;
  logic          enc_err;
  logic          accept;

  riscv_encoder u_enc (
    .opcode_i  (opcode_i),
    .rd_i      (rd_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .func3_i   (func3_i),
    .func7_i   (func7_i),
    .imm_i     (imm_i),
    .inst_o    (enc_word),
    .enc_err_o (enc_err)
  );

  // Ready depends only on registered state, never on in_valid_i.
  always_comb begin
    in_ready_o = (state == S_LOAD) && (count_o != FULL_CNT);
    busy_o     = (state != S_IDLE);
    accept     = in_valid_i && in_ready_o;
  end

  // Session FSM plus registered write port; an accepted beat appears on the
  // write port the following cycle. Reaching full capacity marks an error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      addr       <= '0;
      count_o    <= '0;
      err_o      <= 1'b0;
      memWr_en_o <= 1'b0;
      memAddr_o  <= '0;
      memData_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      memWr_en_o <= accept;
      done_o     <= accept && in_last_i;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            addr    <= base_addr_i;
            count_o <= '0;
            err_o   <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            memAddr_o <= addr;
            memData_o <= enc_word;
            addr      <= addr + AW'(1);
            count_o   <= count_o + (AW+1)'(1);
            if (enc_err || (count_o == LAST_CNT)) err_o <= 1'b1;
            if (in_last_i) state <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
